// File: rtl/smi_mem_write_word64_target_if.sv
// smi_mem_write_word64_target_if: SMI request/response flits and local memory write port
interface smi_mem_write_word64_target_if #(parameter int ADDR_WIDTH = 32);
   logic                  smiReqValid;
   logic [7:0]            smiReqEofc;
   logic [63:0]           smiReqData;
   logic                  smiReqStop;
   logic                  smiRespValid;
   logic [7:0]            smiRespEofc;
   logic [63:0]           smiRespData;
   logic                  smiRespStop;
   logic                  memWriteValid;
   logic [ADDR_WIDTH-4:0] memWriteAddr;
   logic [7:0]            memWriteOpts;
   logic [63:0]           memWriteData;
   logic                  memWriteStop;
   modport slave (
      input  smiReqValid, smiReqEofc, smiReqData, smiRespStop, memWriteStop,
      output smiReqStop, smiRespValid, smiRespEofc, smiRespData,
             memWriteValid, memWriteAddr, memWriteOpts, memWriteData
   );
   modport master (
      output smiReqValid, smiReqEofc, smiReqData, smiRespStop, memWriteStop,
      input  smiReqStop, smiRespValid, smiRespEofc, smiRespData,
             memWriteValid, memWriteAddr, memWriteOpts, memWriteData
   );
endinterface

// File: rtl/smi_mem_write_word64_target.sv
// smi_mem_write_word64_target: parses 3-flit SMI write frames, issues one 64-bit memory write, answers with a 1-flit response.
// Optional SMI_MEM_WRITE_TARGET_RANGE_CHECK_EN rejects frames whose address bits above ADDR_WIDTH are non-zero.
module smi_mem_write_word64_target #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                                    clk,
   input  logic                                    srst_n,
   smi_mem_write_word64_target_if.slave            bus,
   output logic [15:0]                             errorCount
);
   typedef enum logic [2:0] {FLIT1, FLIT2, FLIT3, DRAIN, MEMWR, RESP} state_t;
   state_t      state, state_n;
   logic        err, err_n;
   logic [63:3] addr_q;
   logic [63:0] data_q;
   logic [7:0]  opts_q;
   logic        req_xfer, last, range_err, unused_addr;
   assign req_xfer = bus.smiReqValid && !bus.smiReqStop;
   assign last = bus.smiReqEofc != 8'd0;
   assign unused_addr = ^addr_q;
`ifdef SMI_MEM_WRITE_TARGET_RANGE_CHECK_EN
   assign range_err = ({addr_q, 3'b000} >> ADDR_WIDTH) != 64'd0;
`else
   assign range_err = 1'b0;
`endif
   // request is blocked while a write or response is outstanding, and while reset is held
   assign bus.smiReqStop = !srst_n || state == MEMWR || state == RESP;
   assign bus.memWriteValid = state == MEMWR;
   assign bus.memWriteAddr = addr_q[ADDR_WIDTH-1:3];
   assign bus.memWriteOpts = opts_q;
   assign bus.memWriteData = data_q;
   assign bus.smiRespValid = state == RESP;
   assign bus.smiRespEofc = state == RESP ? 8'd2 : 8'd0;
   assign bus.smiRespData = state == RESP ? {54'd0, err, 1'b0, 8'hFE} : 64'd0;
   // frame parser: next state and accumulated error flag
   always_comb begin
      state_n = state;
      err_n = err;
      case (state)
         FLIT1: if (req_xfer) begin
            err_n = err || bus.smiReqData[7:0] != 8'h01 || last;
            state_n = last ? RESP : FLIT2;
         end
         FLIT2: if (req_xfer) begin
            err_n = err || bus.smiReqData[47:32] != 16'd8 || last;
            state_n = last ? RESP : FLIT3;
         end
         FLIT3: if (req_xfer) begin
            err_n = err || !last || range_err;
            state_n = !last ? DRAIN : (err_n ? RESP : MEMWR);
         end
         DRAIN: if (req_xfer && last) state_n = RESP;
         MEMWR: if (!bus.memWriteStop) state_n = RESP;
         RESP: if (!bus.smiRespStop) begin
            err_n = 1'b0;
            state_n = FLIT1;
         end
         default: state_n = FLIT1;
      endcase
   end
   // state, captured frame fields and saturating error counter
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         state <= FLIT1;
         err <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         opts_q <= '0;
         errorCount <= '0;
      end else begin
         state <= state_n;
         err <= err_n;
         if (req_xfer && state == FLIT1) begin
            opts_q <= bus.smiReqData[15:8];
            addr_q[31:3] <= bus.smiReqData[63:35];
         end
         if (req_xfer && state == FLIT2) begin
            addr_q[63:32] <= bus.smiReqData[31:0];
            data_q[15:0] <= bus.smiReqData[63:48];
         end
         if (req_xfer && state == FLIT3) data_q[63:16] <= bus.smiReqData[47:0];
         if (state == RESP && !bus.smiRespStop && err && errorCount != 16'hFFFF)
            errorCount <= errorCount + 16'd1;
      end
   end
endmodule
